multi_cycle_ctrl: RTL
=====================

// Module: multi_cycle_ctrl
// PURPOSE
//  Moore FSM that sequences the multi-cycle MIPS32 datapath: PC, IR, memory, register file, ALU.
//  Drives every datapath mux select: the 4:1 ALU-B select, the 4:1 PC-source select and the 2:1 selects.
//  Sits beside the datapath and takes the opcode field from the IR. Supports R-type, lw, sw, beq, j and addi.
//  Waits on a memory-ready handshake.
// PARAMETERS
//  USE_MEM_READY  1  1: memory states wait for mem_ready. 0: mem_ready is treated as constant 1.
//  STATE_W        4  width of the state register and of the state_dbg port.
// PORTS
//  clk            in   1   single clock; all state updates on rising edge
//  reset          in   1   synchronous, active-high reset
//  opcode         in   6   IR[31:26]; sampled in DECODE
//  mem_ready      in   1   memory access completes this cycle
//  pc_write       out  1   unconditional PC load
//  pc_write_cond  out  1   PC load if ALU zero (beq)
//  i_or_d         out  1   memory address select: 0 = PC, 1 = ALUOut
//  mem_read       out  1   memory read strobe
//  mem_write      out  1   memory write strobe
//  ir_write       out  1   IR load
//  mem_to_reg     out  1   write-back data select: 0 = ALUOut, 1 = MDR
//  reg_dst        out  1   destination register select: 0 = rt, 1 = rd
//  reg_write      out  1   register file write enable
//  alu_src_a      out  1   ALU A select: 0 = PC, 1 = reg A
//  alu_src_b      out  2   ALU B 4:1 select: 00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
//  alu_op         out  2   00 = add, 01 = sub, 10 = funct-decoded
//  pc_source      out  2   PC 4:1 select: 00 = ALU result, 01 = ALUOut, 10 = jump target
//  instr_done     out  1   1-cycle pulse on the last cycle of each legal instruction
//  illegal_op     out  1   1-cycle pulse in DECODE when the opcode is unsupported
//  state_dbg      out  STATE_W  current state encoding
// BEHAVIOUR
//  State encoding:
//   FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5,
//   EXECUTE=6, ALU_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11.
//  Codes 12-15 are unreachable; if entered, the next state is FETCH.
//  Outputs are combinational from state (plus mem_ready / opcode where noted). Any output not listed for a state is 0.
//  Reset:
//   - While reset=1, all outputs are 0 and state_dbg reads 0.
//   - On the first edge with reset=1, state becomes FETCH, including mid-instruction.
//   - No partial memory or register write is issued in the cycle after reset deasserts.
//  Per-state outputs and transitions:
//   FETCH: mem_read=1, alu_src_b=01, alu_op=00, pc_source=00.
//    ir_write=pc_write=mem_ready. Stays in FETCH while !mem_ready; otherwise goes to DECODE.
//   DECODE: alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
//    - 0x00 -> EXECUTE
//    - 0x23 or 0x2B -> MEM_ADDR
//    - 0x04 -> BRANCH
//    - 0x02 -> JUMP
//    - 0x08 -> ADDI_EX
//    - any other -> FETCH, with illegal_op=1 for that cycle
//   MEM_ADDR: alu_src_a=1, alu_src_b=10. Next is MEM_READ if opcode=0x23, otherwise MEM_WRITE.
//   MEM_READ: mem_read=1, i_or_d=1. Holds until mem_ready, then goes to MEM_WB.
//   MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next is FETCH.
//   MEM_WRITE: mem_write=1, i_or_d=1. Holds until mem_ready.
//    instr_done=mem_ready. Next is FETCH.
//   EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next is ALU_WB.
//   ALU_WB: reg_write=1, reg_dst=1, instr_done=1. Next is FETCH.
//   BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Next is FETCH.
//   JUMP: pc_write=1, pc_source=10, instr_done=1. Next is FETCH.
//   ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Next is ADDI_WB.
//   ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next is FETCH.
//  Memory handshake:
//   - mem_read and mem_write are held steady for the whole wait.
//   - mem_read and mem_write are never both 1.
//  Latency with mem_ready always 1:
//   R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles. Each wait cycle adds 1.
//  opcode is used only in DECODE and MEM_ADDR. IR is stable there because ir_write is only ever asserted in FETCH.
// TESTING
//  1. reset=1 for 2 cycles, then release with mem_ready=1 -> all outputs 0 during reset;
//     first post-reset cycle shows state_dbg=0, mem_read=1, pc_write=1, alu_src_b=01.
//  2. opcode=0x00, mem_ready=1 -> states 0,1,6,7; reg_write=1 and reg_dst=1 in cycle 4;
//     instr_done pulses once; state returns to 0.
//  3. opcode=0x23, mem_ready low for 3 cycles in MEM_READ -> state 3 held 4 cycles with mem_read=1 and i_or_d=1;
//     then MEM_WB with mem_to_reg=1; total 8 cycles.
//  4. opcode=0x04, then opcode=0x02 -> BRANCH gives pc_write_cond=1, pc_source=01, alu_op=01;
//     JUMP gives pc_write=1, pc_source=10; each instruction takes 3 cycles.
//  5. opcode=0x3F -> DECODE pulses illegal_op=1; next state 0; no reg_write or mem_write is ever asserted.
//  6. reset asserted in MEM_WRITE while mem_ready=0 -> mem_write drops to 0 immediately;
//     state 0 after the edge; USE_MEM_READY=0 run of sw takes 4 cycles regardless of mem_ready.

Source files
------------

// File: rtl/multi_cycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : multi_cycle_ctrl_if
// Purpose : Control/status bundle between the multi-cycle controller and datapath.
// Revision: 1.0
// ============================================================================
interface multi_cycle_ctrl_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         opcode;
    logic               mem_ready;
    logic               pc_write;
    logic               pc_write_cond;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic [1:0]         pc_source;
    logic               instr_done;
    logic               illegal_op;
    logic [STATE_W-1:0] state_dbg;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, illegal_op, state_dbg
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, illegal_op, state_dbg
    );
endinterface
`default_nettype wire

// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : multi_cycle_ctrl
// Purpose : Moore sequencer for the multi-cycle MIPS32 datapath with memory handshake.
// Revision: 1.0
// ============================================================================
module multi_cycle_ctrl #(
    parameter bit USE_MEM_READY = 1'b1,
    parameter int STATE_W       = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    multi_cycle_ctrl_if.master bus
);
    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = STATE_W'(0),
        S_DECODE    = STATE_W'(1),
        S_MEM_ADDR  = STATE_W'(2),
        S_MEM_READ  = STATE_W'(3),
        S_MEM_WB    = STATE_W'(4),
        S_MEM_WRITE = STATE_W'(5),
        S_EXECUTE   = STATE_W'(6),
        S_ALU_WB    = STATE_W'(7),
        S_BRANCH    = STATE_W'(8),
        S_JUMP      = STATE_W'(9),
        S_ADDI_EX   = STATE_W'(10),
        S_ADDI_WB   = STATE_W'(11)
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;

    state_t r_state;
    logic   w_ready;

    assign w_ready = USE_MEM_READY ? bus.mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:     r_state <= w_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (bus.opcode)
                        c_OP_RTYPE:      r_state <= S_EXECUTE;
                        c_OP_LW, c_OP_SW: r_state <= S_MEM_ADDR;
                        c_OP_BEQ:        r_state <= S_BRANCH;
                        c_OP_J:          r_state <= S_JUMP;
                        c_OP_ADDI:       r_state <= S_ADDI_EX;
                        default:         r_state <= S_FETCH;
                    endcase
                end
                S_MEM_ADDR:  r_state <= (bus.opcode == c_OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ:  r_state <= w_ready ? S_MEM_WB : S_MEM_READ;
                S_MEM_WRITE: r_state <= w_ready ? S_FETCH : S_MEM_WRITE;
                S_EXECUTE:   r_state <= S_ALU_WB;
                S_ADDI_EX:   r_state <= S_ADDI_WB;
                default:     r_state <= S_FETCH;
            endcase
        end
    end

    // Outputs are decoded from state and forced low while reset is held,
    // so an interrupted memory write is withdrawn in the same cycle.
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.pc_source     = 2'b00;
        bus.instr_done    = 1'b0;
        bus.illegal_op    = 1'b0;
        case (r_state)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = w_ready;
                bus.pc_write  = w_ready;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b11;
                case (bus.opcode)
                    c_OP_RTYPE, c_OP_LW, c_OP_SW, c_OP_BEQ, c_OP_J, c_OP_ADDI: bus.illegal_op = 1'b0;
                    default: bus.illegal_op = 1'b1;
                endcase
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                bus.mem_write  = 1'b1;
                bus.i_or_d     = 1'b1;
                bus.instr_done = w_ready;
            end
            S_EXECUTE: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
            end
            S_ALU_WB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = 2'b01;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 2'b01;
                bus.instr_done    = 1'b1;
            end
            S_JUMP: begin
                bus.pc_write   = 1'b1;
                bus.pc_source  = 2'b10;
                bus.instr_done = 1'b1;
            end
            S_ADDI_EX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_ADDI_WB: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            bus.pc_write      = 1'b0;
            bus.pc_write_cond = 1'b0;
            bus.i_or_d        = 1'b0;
            bus.mem_read      = 1'b0;
            bus.mem_write     = 1'b0;
            bus.ir_write      = 1'b0;
            bus.mem_to_reg    = 1'b0;
            bus.reg_dst       = 1'b0;
            bus.reg_write     = 1'b0;
            bus.alu_src_a     = 1'b0;
            bus.alu_src_b     = 2'b00;
            bus.alu_op        = 2'b00;
            bus.pc_source     = 2'b00;
            bus.instr_done    = 1'b0;
            bus.illegal_op    = 1'b0;
        end
    end

    assign bus.state_dbg = reset ? '0 : r_state;

endmodule
`default_nettype wire
